// File: rtl/bus_initiator.sv
// bus_initiator: master end of the 16-bit daisy-chained register bus.
// Takes one command at a time, launches it as a single-cycle valid_o pulse
// at the head of the core chain, waits for it to come back at the tail and
// hands the captured result (with timeout/mismatch flags) to the host side.
module bus_initiator #(
    parameter int TIMEOUT = 1024,
    parameter int STRAY_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,

    // command port (host side)
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_rw,
    input  logic [15:0]        cmd_addr,
    input  logic [15:0]        cmd_wdata,

    // response port (host side)
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [15:0]        resp_rdata,
    output logic               resp_timeout,
    output logic               resp_mismatch,

    // status
    output logic               busy,
    output logic [STRAY_W-1:0] stray_count,

    // bus towards the first core
    output logic [15:0]        addr_o,
    output logic [15:0]        wdata_o,
    output logic [15:0]        rdata_o,
    output logic               rw_o,
    output logic               valid_o,

    // bus returning from the last core
    input  logic [15:0]        addr_i,
    input  logic [15:0]        wdata_i,
    input  logic [15:0]        rdata_i,
    input  logic               rw_i,
    input  logic               valid_i
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] wait_cnt;

    logic accept;   // command handshake this cycle
    logic ret;      // transaction returns this cycle
    logic expire;   // WAIT runs out without a return this cycle

    // The initiator never originates read data on the chain.
    assign rdata_o = '0;

    // Returned write data carries no information for the initiator.
    logic unused_wdata;
    assign unused_wdata = ^wdata_i;

    assign accept = (state_q == ST_IDLE) && cmd_valid;
    assign ret    = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && valid_i;
    assign expire = (state_q == ST_WAIT) && !valid_i && (wait_cnt == CNT_LAST);

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state decode and state-derived handshake/strobe outputs.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a latch.
        state_d    = state_q;
        cmd_ready  = 1'b0;
        valid_o    = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                valid_o = 1'b1;
                state_d = valid_i ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                // A return in the last WAIT cycle beats the timeout.
                if (valid_i || (wait_cnt == CNT_LAST)) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issued command: loaded on accept, held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_o  <= '0;
            wdata_o <= '0;
            rw_o    <= 1'b0;
        end else if (accept) begin
            addr_o  <= cmd_addr;
            wdata_o <= cmd_wdata;
            rw_o    <= cmd_rw;
        end
    end

    // Wait counter: cleared while issuing, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_q == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Response fields: captured on return or on expiry, stable through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata    <= '0;
            resp_timeout  <= 1'b0;
            resp_mismatch <= 1'b0;
        end else if (ret) begin
            resp_rdata    <= rdata_i;
            resp_timeout  <= 1'b0;
            resp_mismatch <= (addr_i != addr_o) || (rw_i != rw_o);
        end else if (expire) begin
            resp_rdata    <= '0;
            resp_timeout  <= 1'b1;
            resp_mismatch <= 1'b0;
        end
    end

    // Saturating count of returns arriving while no transaction is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stray_count <= '0;
        end else if (valid_i && ((state_q == ST_IDLE) || (state_q == ST_RESP))
                     && (stray_count != '1)) begin
            stray_count <= stray_count + STRAY_W'(1);
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Testbench for bus_initiator: the bench plays both the host and a chain of
// block_memory cores, with a word-array model of the memory and latency
// rules taken straight from the block's behaviour.
module tb_bus_initiator;

    localparam int TO   = 16;
    localparam int SW   = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_rw;
    logic [15:0]   cmd_addr, cmd_wdata;
    logic          resp_valid, resp_ready, resp_timeout, resp_mismatch;
    logic [15:0]   resp_rdata;
    logic          busy;
    logic [SW-1:0] stray_count;
    logic [15:0]   addr_o, wdata_o, rdata_o;
    logic          rw_o, valid_o;
    logic [15:0]   addr_i, wdata_i, rdata_i;
    logic          rw_i, valid_i;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            strays   = 0;
    logic [15:0]   mem [0:7];

    bus_initiator #(.TIMEOUT(TO), .STRAY_W(SW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rw        (cmd_rw),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_timeout  (resp_timeout),
        .resp_mismatch (resp_mismatch),
        .busy          (busy),
        .stray_count   (stray_count),
        .addr_o        (addr_o),
        .wdata_o       (wdata_o),
        .rdata_o       (rdata_o),
        .rw_o          (rw_o),
        .valid_o       (valid_o),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rdata_i       (rdata_i),
        .rw_i          (rw_i),
        .valid_i       (valid_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Return bus carries noise whenever valid_i is low.
    task automatic bus_noise();
        valid_i = 1'b0;
        addr_i  = 16'($urandom);
        wdata_i = 16'($urandom);
        rdata_i = 16'($urandom);
        rw_i    = 1'($urandom);
    endtask

    task automatic stray_pulse();
        bus_noise();
        valid_i = 1'b1;
        tick();
        bus_noise();
        if (strays < SMAX) strays++;
        check("stray_count", stray_count, strays);
        check("stray_no_resp", resp_valid, 1'b0);
        check("stray_idle", busy, 1'b0);
    endtask

    // One complete transaction. dly = cycles from the valid_o cycle to the
    // return cycle (0 = loopback); dly < 0 means nothing ever comes back.
    task automatic run_txn(input bit rw, input logic [15:0] addr, input logic [15:0] wdata,
                           input int dly, input logic [15:0] addr_flip, input bit rw_flip,
                           input int hold, input bit stray_in_hold);
        logic [15:0] exp_rdata;
        bit          exp_to, exp_mm;
        int          resp_at;

        check("idle_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        cmd_rw    = 1'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_wdata = 16'($urandom);
        check("issue_valid_o", valid_o, 1'b1);
        check("issue_addr_o", addr_o, addr);
        check("issue_wdata_o", wdata_o, wdata);
        check("issue_rw_o", rw_o, rw);
        check("issue_busy", busy, 1'b1);
        check("issue_not_ready", cmd_ready, 1'b0);

        // Reference: the memory chain performs the access; the initiator
        // reports either the returned data or an abandoned transaction.
        if (rw) mem[addr[2:0]] = wdata;
        if (dly >= 0 && dly <= TO) begin
            exp_to    = 1'b0;
            exp_rdata = mem[addr[2:0]];
            exp_mm    = (addr_flip != 16'h0) || rw_flip;
            resp_at   = dly + 1;
        end else begin
            exp_to    = 1'b1;
            exp_rdata = 16'h0;
            exp_mm    = 1'b0;
            resp_at   = TO + 1;
        end

        for (int cyc = 0; cyc < resp_at; cyc++) begin
            if (cyc > 0) check("no_early_resp", resp_valid, 1'b0);
            if (cyc == 1) check("valid_o_one_cycle", valid_o, 1'b0);
            bus_noise();
            if (cyc == dly) begin
                valid_i = 1'b1;
                addr_i  = addr ^ addr_flip;
                rw_i    = rw ^ rw_flip;
                rdata_i = mem[addr[2:0]];
            end
            tick();
        end
        bus_noise();

        check("resp_valid", resp_valid, 1'b1);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_timeout", resp_timeout, exp_to);
        check("resp_mismatch", resp_mismatch, exp_mm);

        for (int i = 0; i < hold; i++) begin
            resp_ready = 1'b0;
            cmd_valid  = 1'b1;
            cmd_rw     = 1'($urandom);
            cmd_addr   = 16'($urandom);
            if (stray_in_hold && i == 0) begin
                valid_i = 1'b1;
                if (strays < SMAX) strays++;
            end
            tick();
            bus_noise();
            check("hold_resp_valid", resp_valid, 1'b1);
            check("hold_rdata", resp_rdata, exp_rdata);
            check("hold_timeout", resp_timeout, exp_to);
            check("hold_mismatch", resp_mismatch, exp_mm);
            check("hold_not_ready", cmd_ready, 1'b0);
        end
        cmd_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("after_hs_resp_valid", resp_valid, 1'b0);
        check("after_hs_busy", busy, 1'b0);
        check("after_hs_ready", cmd_ready, 1'b1);
        check("after_hs_valid_o", valid_o, 1'b0);
        check("after_hs_stray", stray_count, strays);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_rw     = 1'b0;
        cmd_addr   = 16'h0;
        cmd_wdata  = 16'h0;
        resp_ready = 1'b0;
        bus_noise();
        tick();
        tick();

        // Reset state
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_addr_o", addr_o, 16'h0);
        check("rst_wdata_o", wdata_o, 16'h0);
        check("rst_rw_o", rw_o, 1'b0);
        check("rst_rdata_o", rdata_o, 16'h0);
        check("rst_stray", stray_count, 0);
        check("rst_resp_rdata", resp_rdata, 16'h0);
        check("rst_resp_flags", {resp_timeout, resp_mismatch}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Write then read-back through a 2-cycle chain
        run_txn(1'b1, 16'h0002, 16'h0001, 2, 16'h0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 16'h0002, 16'h0000, 2, 16'h0, 1'b0, 0, 1'b0);
        check("readback_2", mem[2], 16'h0001);
        run_txn(1'b1, 16'h0000, 16'h6789, 2, 16'h0, 1'b0, 0, 1'b0);
        run_txn(1'b1, 16'h0001, 16'h2345, 2, 16'h0, 1'b0, 1, 1'b0);
        run_txn(1'b1, 16'h0003, 16'h1111, 2, 16'h0, 1'b0, 0, 1'b0);
        run_txn(1'b1, 16'h0004, 16'h1111, 2, 16'h0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 16'h0000, 16'h0000, 2, 16'h0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 16'h0001, 16'h0000, 2, 16'h0, 1'b0, 2, 1'b0);
        run_txn(1'b0, 16'h0003, 16'h0000, 2, 16'h0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 16'h0004, 16'h0000, 2, 16'h0, 1'b0, 0, 1'b0);

        // Zero-core loopback and a return in the very last WAIT cycle
        run_txn(1'b0, 16'h0001, 16'h0000, 0, 16'h0, 1'b0, 0, 1'b0);
        run_txn(1'b0, 16'h0000, 16'h0000, TO, 16'h0, 1'b0, 0, 1'b0);

        // Timeout, then the late return and more strays in IDLE
        run_txn(1'b0, 16'h0007, 16'h0000, -1, 16'h0, 1'b0, 2, 1'b0);
        for (int i = 0; i < 5; i++) stray_pulse();

        // Mismatch (0x0004 issued, 0x0005 returned) under backpressure
        run_txn(1'b0, 16'h0004, 16'h0000, 2, 16'h0001, 1'b0, 10, 1'b1);
        run_txn(1'b1, 16'h0005, 16'hbeef, 3, 16'h0000, 1'b1, 0, 1'b0);

        // Reset three cycles into WAIT
        cmd_valid = 1'b1;
        cmd_rw    = 1'b0;
        cmd_addr  = 16'h0003;
        tick();
        cmd_valid = 1'b0;
        check("rstw_issue", valid_o, 1'b1);
        tick();
        tick();
        tick();
        check("rstw_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstw_busy", busy, 1'b0);
        check("rstw_cmd_ready", cmd_ready, 1'b1);
        check("rstw_resp_valid", resp_valid, 1'b0);
        check("rstw_valid_o", valid_o, 1'b0);
        check("rstw_stray", stray_count, 0);
        strays = 0;
        tick();
        rst_n = 1'b1;
        tick();
        run_txn(1'b0, 16'h0003, 16'h0000, 2, 16'h0, 1'b0, 0, 1'b0);

        // Randomised traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            int          r, dly, hold;
            logic [15:0] flip;
            bit          rwf;
            r    = int'($urandom_range(0, 9));
            dly  = (r == 0) ? -1 : (r == 1) ? TO : int'($urandom_range(0, 5));
            flip = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
            rwf  = ($urandom_range(0, 5) == 0);
            hold = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) stray_pulse();
            run_txn(1'($urandom), 16'($urandom_range(0, 7)), 16'($urandom), dly, flip, rwf,
                    hold, ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
